ex_alu_stage: RTL and testbench
===============================

// Module: ex_alu_stage
// PURPOSE
//  Execute-stage ALU plus EX/MEM result register for the 16-bit pipelined core.
//  Computes ADD/SUB (saturating), XOR, RED, SLL/SRA/ROR and the 4x4-bit saturating PADDSB
//  via the existing PSA_16bit instance, then registers result and valid.
//  Owns the architectural Z/V/N flag register consumed by branch resolution.
//  Sits between ID/EX operand muxing (upstream) and the MEM stage (downstream).
// PARAMETERS
//  none (datapath fixed at 16 bits, opcode at 4 bits)
// PORTS
//  clk        in   1   system clock; all state updates on rising edge
//  rst_n      in   1   synchronous active-low reset
//  stall      in   1   hold stage: registers keep current values
//  flush      in   1   squash the incoming op (branch mispredict)
//  in_valid   in   1   operands/opcode below carry a real instruction
//  opcode     in   4   instruction opcode
//  alu_a      in   16  operand A (forwarded rs)
//  alu_b      in   16  operand B (forwarded rt, or imm for shifts/LW/SW/LLB/LHB)
//  out_valid  out  1   registered: alu_res holds a retiring instruction
//  alu_res    out  16  registered result to MEM stage
//  flag_z     out  1   registered zero flag
//  flag_v     out  1   registered overflow flag
//  flag_n     out  1   registered negative flag
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): out_valid=0, alu_res=16'h0000, Z=V=N=0. Overrides stall/flush.
//  Latency: one cycle; result of op sampled at edge k is on alu_res after edge k.
//  Priority per edge: reset > flush > stall > normal capture.
//  flush=1: out_valid<=0, alu_res<=0, flags hold; op discarded even if stall=1.
//  stall=1 (no flush): out_valid, alu_res, flags all hold; inputs ignored.
//  Normal: out_valid<=in_valid; alu_res<=f(opcode); flags update only if in_valid=1.
//  Opcodes (f, flag effect):
//   0000 ADD : A+B, sat to 16'h7FFF / 16'h8000 on signed ovfl; sets Z,V,N
//   0001 SUB : A-B, same saturation; sets Z,V,N (V = signed ovfl before saturation)
//   0010 XOR : A^B; sets Z only (V,N hold)
//   0011 RED : sext16( sx(A[15:8])+sx(A[7:0])+sx(B[15:8])+sx(B[7:0]) ); flags hold
//   0100 SLL : A << B[3:0]; sets Z only
//   0101 SRA : A >>> B[3:0] (sign fill); sets Z only
//   0110 ROR : A rotated right by B[3:0]; sets Z only
//   0111 PADDSB : PSA_16bit(A,B), each nibble sat to 4'h7/4'h8; flags hold
//   1000/1001 LW/SW addr : (A & 16'hFFFE)+B, wraps mod 2^16, no sat; flags hold
//   1010-1111 : alu_res = B pass-through; flags hold
//  Z computed on the final (saturated) 16-bit result; N = result[15]; V = 1 only on ADD/SUB ovfl.
//  in_valid=0 with no stall/flush: out_valid<=0, alu_res still captures f(opcode), flags hold.
//  Shift amount 0: result = A unchanged. RED max magnitude fits 10 bits, sign-extend to 16.
// TESTING
//  ADD A=16'h7FFF B=16'h0001 -> next cycle alu_res=16'h7FFF, V=1 N=0 Z=0, out_valid=1
//  SUB A=16'h0005 B=16'h0005 -> alu_res=16'h0000, Z=1 V=0 N=0; then XOR 16'h00F0^16'h000F
//   -> alu_res=16'h00FF, Z=0, V/N unchanged from SUB
//  PADDSB A=16'h7171 B=16'h1111 -> alu_res=16'h7272 nibble sat: A=16'h0008 B=16'h0008
//   -> alu_res=16'h0008? no: low nibble 8+8 neg ovfl -> 16'h0008 (4'h8); flags unchanged
//  SRA A=16'h8000 B=4'hF -> 16'hFFFF, Z=0; ROR A=16'h0001 B=4'h1 -> 16'h8000
//  ADD issued with stall=1 for 2 cycles -> alu_res/flags frozen; flush+stall same edge
//   -> out_valid=0, flags unchanged
//  rst_n=0 mid-stream with in_valid=1 -> next edge out_valid=0, alu_res=0, Z=V=N=0

Source files
------------

// File: rtl/ex_alu_stage.sv
// ---------------------------------------------------------------------------
// ex_alu_stage
// Execute-stage ALU and EX/MEM result register for the 16-bit pipelined core.
// Computes saturating ADD/SUB, XOR, RED, SLL/SRA/ROR, the 4x4-bit saturating
// PADDSB and LW/SW address generation, then registers the result and valid.
// Also owns the architectural Z/V/N flag register read by branch resolution.
//
// Ports
//   clk        : system clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset
//   stall      : hold the stage, all registers keep their values
//   flush      : squash the incoming op (branch mispredict)
//   in_valid   : opcode/operands carry a real instruction
//   opcode     : 4-bit instruction opcode
//   alu_a      : operand A (forwarded rs)
//   alu_b      : operand B (forwarded rt or immediate)
//   out_valid  : alu_res holds a retiring instruction
//   alu_res    : registered result towards MEM
//   flag_z/v/n : registered zero / overflow / negative flags
//
// Handshake: no backpressure. An op is accepted on an edge where
// rst_n=1, flush=0, stall=0; it retires (out_valid=1) one cycle later only if
// in_valid was 1. Priority on every edge: reset > flush > stall > capture.
// ---------------------------------------------------------------------------
module ex_alu_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        in_valid,
   input  logic [3:0]  opcode,
   input  logic [15:0] alu_a,
   input  logic [15:0] alu_b,
   output logic        out_valid,
   output logic [15:0] alu_res,
   output logic        flag_z,
   output logic        flag_v,
   output logic        flag_n
);

   // Saturating add/sub: overflow seen from operand and result signs.
   logic [15:0] add_raw;
   logic [15:0] sub_raw;
   logic        add_ovfl;
   logic        sub_ovfl;

   assign add_raw  = alu_a + alu_b;
   assign sub_raw  = alu_a - alu_b;
   assign add_ovfl = (alu_a[15] == alu_b[15]) && (add_raw[15] != alu_a[15]);
   assign sub_ovfl = (alu_a[15] != alu_b[15]) && (sub_raw[15] != alu_a[15]);

   // On overflow the true result has the sign of A, so clamp toward it.
   logic [15:0] add_sat;
   logic [15:0] sub_sat;

   assign add_sat = add_ovfl ? (alu_a[15] ? 16'h8000 : 16'h7FFF) : add_raw;
   assign sub_sat = sub_ovfl ? (alu_a[15] ? 16'h8000 : 16'h7FFF) : sub_raw;

   // RED: four signed bytes summed in 10 bits (max magnitude 512 fits).
   logic [9:0]  red_sum;
   logic [15:0] red_res;

   assign red_sum = {{2{alu_a[15]}}, alu_a[15:8]} + {{2{alu_a[7]}}, alu_a[7:0]}
                  + {{2{alu_b[15]}}, alu_b[15:8]} + {{2{alu_b[7]}}, alu_b[7:0]};
   assign red_res = {{6{red_sum[9]}}, red_sum};

   // PSA_16bit: four independent signed nibble adders with saturation.
   logic [15:0] psa_res;

   for (genvar i = 0; i < 4; i++) begin : g_psa
      logic [3:0] na;
      logic [3:0] nb;
      logic [3:0] ns;
      logic       novfl;
      assign na    = alu_a[4*i +: 4];
      assign nb    = alu_b[4*i +: 4];
      assign ns    = na + nb;
      assign novfl = (na[3] == nb[3]) && (ns[3] != na[3]);
      assign psa_res[4*i +: 4] = novfl ? (na[3] ? 4'h8 : 4'h7) : ns;
   end

   // Shifts; rotate uses the doubled word so a zero amount returns A.
   logic [3:0]  shamt;
   logic [31:0] ror_wide;
   logic [15:0] sra_res;

   assign shamt    = alu_b[3:0];
   assign ror_wide = {alu_a, alu_a} >> shamt;
   assign sra_res  = $signed(alu_a) >>> shamt;

   // Result select and which flags the op is allowed to write.
   logic [15:0] res_next;
   logic        upd_z;
   logic        upd_vn;
   logic        v_next;

   always_comb begin
      res_next = alu_b;
      upd_z    = 1'b0;
      upd_vn   = 1'b0;
      v_next   = 1'b0;
      case (opcode)
         4'b0000: begin res_next = add_sat; upd_z = 1'b1; upd_vn = 1'b1; v_next = add_ovfl; end
         4'b0001: begin res_next = sub_sat; upd_z = 1'b1; upd_vn = 1'b1; v_next = sub_ovfl; end
         4'b0010: begin res_next = alu_a ^ alu_b; upd_z = 1'b1; end
         4'b0011: res_next = red_res;
         4'b0100: begin res_next = alu_a << shamt; upd_z = 1'b1; end
         4'b0101: begin res_next = sra_res; upd_z = 1'b1; end
         4'b0110: begin res_next = ror_wide[15:0]; upd_z = 1'b1; end
         4'b0111: res_next = psa_res;
         4'b1000,
         4'b1001: res_next = (alu_a & 16'hFFFE) + alu_b;
         default: res_next = alu_b;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         alu_res   <= 16'h0000;
         flag_z    <= 1'b0;
         flag_v    <= 1'b0;
         flag_n    <= 1'b0;
      end else if (flush) begin
         // Squash even when stalled; flags keep their last committed values.
         out_valid <= 1'b0;
         alu_res   <= 16'h0000;
      end else if (!stall) begin
         out_valid <= in_valid;
         alu_res   <= res_next;
         if (in_valid) begin
            if (upd_z) begin
               flag_z <= (res_next == 16'h0000);
            end
            if (upd_vn) begin
               flag_v <= v_next;
               flag_n <= res_next[15];
            end
         end
      end
   end

endmodule

// File: tb/tb_ex_alu_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_alu_stage
// Self-checking bench for ex_alu_stage: directed vectors with literal
// expectations, stall/flush scenarios and randomized traffic checked against
// an arithmetic reference model of the stage.
// ---------------------------------------------------------------------------
module tb_ex_alu_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic        in_valid;
   logic [3:0]  opcode;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic        out_valid;
   logic [15:0] alu_res;
   logic        flag_z;
   logic        flag_v;
   logic        flag_n;

   int checks = 0;
   int passed = 0;

   // Reference model state
   logic        m_valid = 1'b0;
   logic [15:0] m_res   = 16'h0;
   logic        m_z = 1'b0, m_v = 1'b0, m_n = 1'b0;

   logic [55:0] dir_tab [14];

   ex_alu_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall     (stall),
      .flush     (flush),
      .in_valid  (in_valid),
      .opcode    (opcode),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .out_valid (out_valid),
      .alu_res   (alu_res),
      .flag_z    (flag_z),
      .flag_v    (flag_v),
      .flag_n    (flag_n)
   );

   // clock / reset block
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int sval(input int v, input int bits);
      int half;
      half = 1 << (bits - 1);
      return (v >= half) ? v - (1 << bits) : v;
   endfunction

   function automatic int clamp(input int v, input int lo, input int hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic void ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] r, output logic uz, output logic uvn,
                                   output logic v);
      int sa, sb, s, sh;
      logic [15:0] t;
      sa = sval(int'(a), 16);
      sb = sval(int'(b), 16);
      sh = int'(b[3:0]);
      uz = 1'b0; uvn = 1'b0; v = 1'b0; r = b;
      case (op)
         4'd0, 4'd1: begin
            s  = (op == 4'd0) ? sa + sb : sa - sb;
            v  = (s > 32767) || (s < -32768);
            s  = clamp(s, -32768, 32767);
            r  = s[15:0];
            uz = 1'b1; uvn = 1'b1;
         end
         4'd2: begin r = a ^ b; uz = 1'b1; end
         4'd3: begin
            s = sval(int'(a[15:8]), 8) + sval(int'(a[7:0]), 8)
              + sval(int'(b[15:8]), 8) + sval(int'(b[7:0]), 8);
            r = s[15:0];
         end
         4'd4: begin s = int'(a) * (1 << sh); r = s[15:0]; uz = 1'b1; end
         4'd5: begin
            s = sa;
            for (int k = 0; k < sh; k++) s = (s < 0 && (s % 2 != 0)) ? (s - 1) / 2 : s / 2;
            r = s[15:0]; uz = 1'b1;
         end
         4'd6: begin
            t = a;
            for (int k = 0; k < sh; k++) t = {t[0], t[15:1]};
            r = t; uz = 1'b1;
         end
         4'd7: begin
            for (int k = 0; k < 4; k++) begin
               s = clamp(sval(int'((a >> (4*k)) & 16'hF), 4) + sval(int'((b >> (4*k)) & 16'hF), 4), -8, 7);
               r[4*k +: 4] = s[3:0];
            end
         end
         4'd8, 4'd9: begin
            s = ((int'(a) / 2) * 2 + int'(b)) % 65536;
            r = s[15:0];
         end
         default: r = b;
      endcase
   endfunction

   task automatic model_step();
      logic [15:0] r;
      logic uz, uvn, v;
      if (!rst_n) begin
         m_valid = 1'b0; m_res = 16'h0; m_z = 1'b0; m_v = 1'b0; m_n = 1'b0;
      end else if (flush) begin
         m_valid = 1'b0; m_res = 16'h0;
      end else if (!stall) begin
         ref_alu(opcode, alu_a, alu_b, r, uz, uvn, v);
         m_valid = in_valid;
         m_res   = r;
         if (in_valid) begin
            if (uz) m_z = (r == 16'h0);
            if (uvn) begin m_v = v; m_n = r[15]; end
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic r, input logic s, input logic f, input logic iv,
                        input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      rst_n = r; stall = s; flush = f; in_valid = iv; opcode = op; alu_a = a; alu_b = b;
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
      step();
      step();
      checks++;
      if ({out_valid, alu_res, flag_z, flag_v, flag_n} !== 20'h0)
         $display("FAIL reset: got %h want %h", {out_valid, alu_res, flag_z, flag_v, flag_n}, 20'h0);
      else passed++;
   endtask

   task automatic test_directed();
      logic [19:0] exp;
      //                  op     A         B         v     res       z v n
      dir_tab[0]  = {4'h0, 16'h7FFF, 16'h0001, 1'b1, 16'h7FFF, 3'b010};
      dir_tab[1]  = {4'h1, 16'h0005, 16'h0005, 1'b1, 16'h0000, 3'b100};
      dir_tab[2]  = {4'h2, 16'h00F0, 16'h000F, 1'b1, 16'h00FF, 3'b000};
      dir_tab[3]  = {4'h7, 16'h7171, 16'h1111, 1'b1, 16'h7272, 3'b000};
      dir_tab[4]  = {4'h7, 16'h0008, 16'h0008, 1'b1, 16'h0008, 3'b000};
      dir_tab[5]  = {4'h5, 16'h8000, 16'h000F, 1'b1, 16'hFFFF, 3'b000};
      dir_tab[6]  = {4'h6, 16'h0001, 16'h0001, 1'b1, 16'h8000, 3'b000};
      dir_tab[7]  = {4'h0, 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 3'b011};
      dir_tab[8]  = {4'h2, 16'h1234, 16'h1234, 1'b1, 16'h0000, 3'b111};
      dir_tab[9]  = {4'h3, 16'h8080, 16'h8080, 1'b1, 16'hFE00, 3'b111};
      dir_tab[10] = {4'h8, 16'h0003, 16'hFFFF, 1'b1, 16'h0001, 3'b111};
      dir_tab[11] = {4'hF, 16'h0000, 16'hABCD, 1'b1, 16'hABCD, 3'b111};
      dir_tab[12] = {4'h4, 16'h1234, 16'h0000, 1'b1, 16'h1234, 3'b011};
      dir_tab[13] = {4'h1, 16'h8000, 16'h0001, 1'b1, 16'h8000, 3'b011};
      for (int i = 0; i < 14; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b1, dir_tab[i][55:52], dir_tab[i][51:36], dir_tab[i][35:20]);
         exp = dir_tab[i][19:0];
         step();
         checks++;
         if ({out_valid, alu_res, flag_z, flag_v, flag_n} !== exp)
            $display("FAIL directed[%0d]: got %h want %h", i, {out_valid, alu_res, flag_z, flag_v, flag_n}, exp);
         else passed++;
      end
   endtask

   task automatic test_stall_flush();
      logic [19:0] exp;
      // Known state with N=1: 0 - 1 = FFFF.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 16'h0000, 16'h0001);
      step();
      // ADD held off by stall for two cycles; everything frozen.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 16'h0000, 16'h0000);
         step();
         exp = {1'b1, 16'hFFFF, 3'b001};
         checks++;
         if ({out_valid, alu_res, flag_z, flag_v, flag_n} !== exp)
            $display("FAIL stall_hold[%0d]: got %h want %h", i, {out_valid, alu_res, flag_z, flag_v, flag_n}, exp);
         else passed++;
      end
      // flush wins over stall; flags untouched.
      drive(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 16'h7FFF, 16'h7FFF);
      step();
      exp = {1'b0, 16'h0000, 3'b001};
      checks++;
      if ({out_valid, alu_res, flag_z, flag_v, flag_n} !== exp)
         $display("FAIL flush_stall: got %h want %h", {out_valid, alu_res, flag_z, flag_v, flag_n}, exp);
      else passed++;
      // Bubble: result still captured, valid low, flags hold.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 16'h00F0, 16'h00F0);
      step();
      exp = {1'b0, 16'h0000, 3'b001};
      checks++;
      if ({out_valid, alu_res, flag_z, flag_v, flag_n} !== exp)
         $display("FAIL bubble: got %h want %h", {out_valid, alu_res, flag_z, flag_v, flag_n}, exp);
      else passed++;
   endtask

   function automatic logic [15:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 16'h7FFF;
         1: return 16'h8000;
         2: return 16'h0000;
         3: return 16'hFFFF;
         default: return 16'($urandom_range(0, 65535));
      endcase
   endfunction

   task automatic test_random();
      logic [19:0] exp;
      for (int i = 0; i < 400; i++) begin
         drive(1'b1, ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 6),
               ($urandom_range(0, 99) < 80), 4'($urandom_range(0, 15)), pick_operand(), pick_operand());
         step();
         exp = {m_valid, m_res, m_z, m_v, m_n};
         checks++;
         if ({out_valid, alu_res, flag_z, flag_v, flag_n} !== exp)
            $display("FAIL random[%0d] op=%h a=%h b=%h: got %h want %h", i, opcode, alu_a, alu_b,
                     {out_valid, alu_res, flag_z, flag_v, flag_n}, exp);
         else passed++;
      end
   endtask

   task automatic test_reset_midstream();
      // Make flags non-zero first so the reset visibly clears them.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 16'h8000, 16'h8000);
      step();
      drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 16'h7FFF, 16'h0001);
      step();
      checks++;
      if ({out_valid, alu_res, flag_z, flag_v, flag_n} !== 20'h0)
         $display("FAIL reset_mid: got %h want %h", {out_valid, alu_res, flag_z, flag_v, flag_n}, 20'h0);
      else passed++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
      test_reset();
      test_directed();
      test_stall_flush();
      test_random();
      test_reset_midstream();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
